// File: rtl/pc_next_unit.sv
// pc_next_unit: program-counter unit. Owns the PC register, resolves branch
// conditions from the ALU flags and selects the next fetch address. After a
// taken redirect it runs a flush window of FLUSH_SLOTS cycles, and a halt
// instruction parks the PC until resume.
// Optional feature: define PC_BRANCH_STATS_EN to add saturating 32-bit
// branch statistics outputs br_taken_cnt and br_total_cnt.
module pc_next_unit #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       INSTR_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
  parameter int unsigned       FLUSH_SLOTS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              instr_valid,
  input  logic [2:0]        br_sel,
  input  logic [1:0]        jmp_sel,
  input  logic              zero,
  input  logic              carry,
  input  logic              overflow,
  input  logic              negative,
  input  logic [ADDR_W-1:0] imm_addr,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [ADDR_W-1:0] br_addr,
  input  logic              resume,
`ifdef PC_BRANCH_STATS_EN
  output logic [31:0]       br_taken_cnt,
  output logic [31:0]       br_total_cnt,
`endif
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        next_sel,
  output logic              redirect,
  output logic              flush,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] INC        = ADDR_W'(INSTR_BYTES);
  // Targets are forced onto an instruction boundary.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(INC - ADDR_W'(1));
  localparam logic [3:0]        FLUSH_INIT = 4'(FLUSH_SLOTS);

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_JMP  = 2'b01;
  localparam logic [1:0] SEL_HOLD = 2'b10;
  localparam logic [1:0] SEL_BR   = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              flush_q, flush_d;
  logic              halted_q, halted_d;

  logic              br_cond;
  logic              take;
  logic [ADDR_W-1:0] target;

  // Branch condition from ALU flags (carry=1 means no borrow).
  always_comb begin
    case (br_sel)
      3'b001:  br_cond = zero;
      3'b010:  br_cond = !zero && (negative == overflow);
      3'b011:  br_cond = !zero;
      3'b100:  br_cond = (negative != overflow);
      3'b101:  br_cond = (negative == overflow);
      3'b110:  br_cond = !carry;
      3'b111:  br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase
  end

  // Next-address decision and next-state; stall freezes everything but the
  // decision itself stays visible on next_sel.
  always_comb begin
    next_sel = SEL_SEQ;
    redirect = 1'b0;
    take     = 1'b0;
    target   = '0;
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    flush_d  = flush_q;
    halted_d = halted_q;

    case (state_q)
      ST_RUN: begin
        if (instr_valid) begin
          if (jmp_sel == 2'b11) begin
            next_sel = SEL_HOLD;
          end else if (jmp_sel == 2'b01) begin
            next_sel = SEL_JMP;
            target   = imm_addr;
            take     = 1'b1;
          end else if (jmp_sel == 2'b10) begin
            next_sel = SEL_JMP;
            target   = reg_addr;
            take     = 1'b1;
          end else if (br_cond) begin
            next_sel = SEL_BR;
            target   = br_addr;
            take     = 1'b1;
          end
        end
        redirect = take && !stall;
        if (!stall) begin
          if (instr_valid && (jmp_sel == 2'b11)) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else if (take) begin
            pc_d = target & ALIGN_MASK;
            if (FLUSH_SLOTS != 0) begin
              state_d = ST_FLUSH;
              cnt_d   = FLUSH_INIT;
              flush_d = 1'b1;
            end
          end else begin
            pc_d = pc_q + INC;
          end
        end
      end
      ST_FLUSH: begin
        // Younger slots are squashed: instr_valid is ignored, fetch goes on.
        if (!stall) begin
          pc_d  = pc_q + INC;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ST_RUN;
            flush_d = 1'b0;
          end
        end
      end
      ST_HALT: begin
        next_sel = SEL_HOLD;
        if (!stall && resume) begin
          pc_d     = pc_q + INC;
          state_d  = ST_RUN;
          halted_d = 1'b0;
        end
      end
      default: begin
        state_d  = ST_RUN;
        flush_d  = 1'b0;
        halted_d = 1'b0;
        cnt_d    = 4'd0;
      end
    endcase
  end

  // PC and control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_ADDR;
      cnt_q    <= 4'd0;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      flush_q  <= flush_d;
      halted_q <= halted_d;
    end
  end

  assign pc     = pc_q;
  assign flush  = flush_q;
  assign halted = halted_q;

`ifdef PC_BRANCH_STATS_EN
  logic        br_seen;
  logic        br_hit;
  logic [31:0] br_taken_q;
  logic [31:0] br_total_q;

  // A branch is counted only when its instruction is accepted; it is taken
  // only if no jump overrides it.
  always_comb begin
    br_seen = instr_valid && !stall && (state_q == ST_RUN) && (br_sel != 3'b000);
    br_hit  = br_seen && (jmp_sel == 2'b00) && br_cond;
  end

  // Saturating branch statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_taken_q <= 32'd0;
      br_total_q <= 32'd0;
    end else begin
      if (br_seen && (br_total_q != 32'hFFFF_FFFF)) br_total_q <= br_total_q + 32'd1;
      if (br_hit && (br_taken_q != 32'hFFFF_FFFF)) br_taken_q <= br_taken_q + 32'd1;
    end
  end

  assign br_taken_cnt = br_taken_q;
  assign br_total_cnt = br_total_q;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit with a cycle-level reference model.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        instr_valid = 1'b0;
  logic [2:0]  br_sel = 3'd0;
  logic [1:0]  jmp_sel = 2'd0;
  logic        zero = 1'b0, carry = 1'b0, overflow = 1'b0, negative = 1'b0;
  logic [31:0] imm_addr = '0, reg_addr = '0, br_addr = '0;
  logic        resume = 1'b0;
  logic [31:0] pc;
  logic [1:0]  next_sel;
  logic        redirect, flush, halted;
  logic [31:0] br_taken_cnt, br_total_cnt;

  // 8-bit instance, used only for wrap-around
  logic        w_zero = 1'b0;
  logic [7:0]  w_addr = 8'd0;
  logic [7:0]  pc8;
  logic [1:0]  nsel8;
  logic        redir8, flush8, halted8;
  logic [31:0] tk8, tt8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pc_next_unit #(.ADDR_W(32), .INSTR_BYTES(4), .RESET_ADDR(32'h100), .FLUSH_SLOTS(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .instr_valid(instr_valid),
    .br_sel(br_sel), .jmp_sel(jmp_sel), .zero(zero), .carry(carry),
    .overflow(overflow), .negative(negative), .imm_addr(imm_addr),
    .reg_addr(reg_addr), .br_addr(br_addr), .resume(resume),
`ifdef PC_BRANCH_STATS_EN
    .br_taken_cnt(br_taken_cnt), .br_total_cnt(br_total_cnt),
`endif
    .pc(pc), .next_sel(next_sel), .redirect(redirect), .flush(flush), .halted(halted)
  );

  pc_next_unit #(.ADDR_W(8), .INSTR_BYTES(4), .RESET_ADDR(8'hF8), .FLUSH_SLOTS(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .stall(w_zero), .instr_valid(w_zero),
    .br_sel(3'b000), .jmp_sel(2'b00), .zero(w_zero), .carry(w_zero),
    .overflow(w_zero), .negative(w_zero), .imm_addr(w_addr),
    .reg_addr(w_addr), .br_addr(w_addr), .resume(w_zero),
`ifdef PC_BRANCH_STATS_EN
    .br_taken_cnt(tk8), .br_total_cnt(tt8),
`endif
    .pc(pc8), .next_sel(nsel8), .redirect(redir8), .flush(flush8), .halted(halted8)
  );

`ifndef PC_BRANCH_STATS_EN
  assign br_taken_cnt = '0;
  assign br_total_cnt = '0;
  assign tk8 = '0;
  assign tt8 = '0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 running, 1 squashing after a redirect, 2 halted
  int          m_mode = 0;
  int          m_left = 0;
  logic [31:0] m_pc = 32'h100;
  logic [31:0] m_tot = 0, m_tak = 0;

  function automatic logic cond_f(input logic [2:0] b, input logic z, c, v, n);
    case (b)
      3'd1: return z;
      3'd2: return !z && (n == v);
      3'd3: return !z;
      3'd4: return n != v;
      3'd5: return n == v;
      3'd6: return !c;
      3'd7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] exp_nsel();
    if (m_mode == 2) return 2'b10;
    if (m_mode == 1 || !instr_valid) return 2'b00;
    if (jmp_sel == 2'b11) return 2'b10;
    if (jmp_sel != 2'b00) return 2'b01;
    return cond_f(br_sel, zero, carry, overflow, negative) ? 2'b11 : 2'b00;
  endfunction

  function automatic logic exp_redir();
    logic [1:0] s;
    s = exp_nsel();
    return (m_mode == 0) && instr_valid && !stall && (s == 2'b01 || s == 2'b11);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_left = 0; m_pc = 32'h100; m_tot = 0; m_tak = 0;
    end else if (!stall) begin
      if (m_mode == 0) begin
        logic [1:0] s;
        s = exp_nsel();
        if (instr_valid && br_sel != 3'd0 && m_tot != 32'hFFFF_FFFF) m_tot = m_tot + 1;
        if (instr_valid && s == 2'b11 && m_tak != 32'hFFFF_FFFF) m_tak = m_tak + 1;
        if (s == 2'b10) m_mode = 2;
        else if (s == 2'b01 || s == 2'b11) begin
          m_pc = (s == 2'b11) ? br_addr : (jmp_sel == 2'b01 ? imm_addr : reg_addr);
          m_pc = m_pc & ~32'h3;
          m_mode = 1; m_left = 2;
        end else m_pc = m_pc + 4;
      end else if (m_mode == 1) begin
        m_pc = m_pc + 4;
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 0;
      end else if (resume) begin
        m_pc = m_pc + 4;
        m_mode = 0;
      end
    end
  end

  // Single compare process, away from the active edge
  always @(negedge clk) begin
    chk("pc", pc, m_pc);
    chk("next_sel", {30'd0, next_sel}, {30'd0, exp_nsel()});
    chk("redirect", {31'd0, redirect}, {31'd0, exp_redir()});
    chk("flush", {31'd0, flush}, {31'd0, (m_mode == 1)});
    chk("halted", {31'd0, halted}, {31'd0, (m_mode == 2)});
`ifdef PC_BRANCH_STATS_EN
    chk("br_total_cnt", br_total_cnt, m_tot);
    chk("br_taken_cnt", br_taken_cnt, m_tak);
`endif
  end

  // ---------------- stimulus ----------------
  // f = {zero, carry, overflow, negative}
  task automatic set_in(input logic iv, input logic [2:0] br, input logic [1:0] jmp,
                        input logic [3:0] f, input logic [31:0] ia, input logic [31:0] ra,
                        input logic [31:0] ba, input logic st, input logic rs);
    instr_valid = iv; br_sel = br; jmp_sel = jmp;
    zero = f[3]; carry = f[2]; overflow = f[1]; negative = f[0];
    imm_addr = ia; reg_addr = ra; br_addr = ba; stall = st; resume = rs;
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 3'd0, 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jump_to(input logic [31:0] a);
    set_in(1'b1, 3'd0, 2'b01, 4'd0, a, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    idle();
  endtask

  logic [2:0] tb_br [8] = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd2, 3'd6, 3'd0, 3'd7};
  logic [3:0] tb_fl [8] = '{4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b1111, 4'b0100};

  initial begin
    idle();
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("reset pc", pc, 32'h100);
    chk("reset flush", {31'd0, flush}, 32'd0);
    chk("reset halted", {31'd0, halted}, 32'd0);
    chk("wrap pc8 start", {24'd0, pc8}, 32'hF8);

    // jump to 0x18, flush through to 0x20
    set_in(1'b1, 3'd0, 2'b01, 4'd0, 32'h18, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("jmp redirect", {31'd0, redirect}, 32'd1);
    chk("jmp next_sel", {30'd0, next_sel}, 32'd1);
    tick();
    chk("jmp pc", pc, 32'h18);
    chk("jmp flush", {31'd0, flush}, 32'd1);
    chk("wrap pc8 FC", {24'd0, pc8}, 32'hFC);
    idle(); tick();
    chk("wrap pc8 00", {24'd0, pc8}, 32'h00);
    tick();
    chk("run pc 20", pc, 32'h20);
    chk("flush done", {31'd0, flush}, 32'd0);

    // GT taken
    set_in(1'b1, 3'b010, 2'b00, 4'b0011, 32'd0, 32'd0, 32'h80, 1'b0, 1'b0);
    chk("GT redirect", {31'd0, redirect}, 32'd1);
    chk("GT next_sel", {30'd0, next_sel}, 32'd3);
    tick();
    chk("GT pc", pc, 32'h80);
    idle(); tick(); tick();

    // GT with zero=1 not taken
    jump_to(32'h18); tick(); tick();
    set_in(1'b1, 3'b010, 2'b00, 4'b1011, 32'd0, 32'd0, 32'h80, 1'b0, 1'b0);
    chk("GT z redirect", {31'd0, redirect}, 32'd0);
    chk("GT z next_sel", {30'd0, next_sel}, 32'd0);
    tick();
    chk("GT z pc", pc, 32'h24);

    // LO with carry=1 not taken
    set_in(1'b1, 3'b110, 2'b00, 4'b0100, 32'd0, 32'd0, 32'h90, 1'b0, 1'b0);
    tick();
    chk("LO pc", pc, 32'h28);
`ifdef PC_BRANCH_STATS_EN
    chk("stats total", br_total_cnt, 32'd3);
    chk("stats taken", br_taken_cnt, 32'd1);
`endif

    // flush window ignores a valid EQ-true branch
    set_in(1'b1, 3'd0, 2'b01, 4'd0, 32'h40, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    chk("flush pc0", pc, 32'h40);
    chk("flush f0", {31'd0, flush}, 32'd1);
    set_in(1'b1, 3'b001, 2'b00, 4'b1000, 32'd0, 32'd0, 32'h200, 1'b0, 1'b0);
    chk("flush squash redirect", {31'd0, redirect}, 32'd0);
    tick();
    chk("flush pc1", pc, 32'h44);
    chk("flush f1", {31'd0, flush}, 32'd1);
    tick();
    chk("flush pc2", pc, 32'h48);
    chk("flush f2", {31'd0, flush}, 32'd0);
    idle(); tick();

    // priority and alignment
    set_in(1'b1, 3'b111, 2'b10, 4'd0, 32'h777, 32'h1236, 32'h999, 1'b0, 1'b0);
    chk("prio next_sel", {30'd0, next_sel}, 32'd1);
    chk("prio redirect", {31'd0, redirect}, 32'd1);
    tick();
    chk("prio pc", pc, 32'h1234);
    idle(); tick(); tick();

    // halt and resume
    jump_to(32'h48); tick(); tick();
    chk("pre-halt pc", pc, 32'h50);
    set_in(1'b1, 3'd0, 2'b11, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("halt next_sel", {30'd0, next_sel}, 32'd2);
    chk("halt redirect", {31'd0, redirect}, 32'd0);
    tick();
    chk("halted", {31'd0, halted}, 32'd1);
    set_in(1'b1, 3'd7, 2'b01, 4'd0, 32'h700, 32'd0, 32'h700, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halt pc hold", pc, 32'h50);
    end
    set_in(1'b0, 3'd0, 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    tick();
    chk("stall resume pc", pc, 32'h50);
    chk("stall resume halted", {31'd0, halted}, 32'd1);
    set_in(1'b0, 3'd0, 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    tick();
    chk("resume pc", pc, 32'h54);
    chk("resume halted", {31'd0, halted}, 32'd0);

    // stall in run and during flush
    set_in(1'b1, 3'd7, 2'd0, 4'd0, 32'd0, 32'd0, 32'h600, 1'b1, 1'b0);
    chk("stall redirect", {31'd0, redirect}, 32'd0);
    chk("stall next_sel", {30'd0, next_sel}, 32'd3);
    tick();
    chk("stall pc", pc, 32'h54);
    set_in(1'b1, 3'd7, 2'd0, 4'd0, 32'd0, 32'd0, 32'h600, 1'b0, 1'b0);
    tick();
    chk("unstall pc", pc, 32'h600);
    set_in(1'b0, 3'd0, 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    chk("flush stall pc", pc, 32'h600);
    chk("flush stall f", {31'd0, flush}, 32'd1);
    idle(); tick(); tick();
    chk("flush stall end", pc, 32'h608);

    // condition table, checked by the model
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, tb_br[i], 2'd0, tb_fl[i], 32'd0, 32'd0, 32'h1000 + 32'(i * 16) + 32'd2, 1'b0, 1'b0);
      tick();
      idle(); tick(); tick();
    end

    // reset in the middle of a flush
    jump_to(32'h300);
    chk("pre-reset flush", {31'd0, flush}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset pc", pc, 32'h100);
    chk("async reset flush", {31'd0, flush}, 32'd0);
    chk("async reset halted", {31'd0, halted}, 32'd0);
`ifdef PC_BRANCH_STATS_EN
    chk("reset stats", br_total_cnt, 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("post-reset pc", pc, 32'h10C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised program-counter unit: owns the PC register, resolves branch conditions from ALU flags and selects the next fetch address.
- Successor to the combinational next-instruction-select decoder. Adds:
  - full condition set (EQ/NE/signed/unsigned compares)
  - PC register with stall
  - post-redirect flush window
  - halt/resume state
- Sits between decode/execute (condition, target inputs) and instruction fetch (pc output).

Parameters:
- ADDR_W, 32, width of PC and all target addresses.
- INSTR_BYTES, 4, PC increment; power of two ≥1.
- RESET_ADDR, 0, PC value after reset.
- FLUSH_SLOTS, 2, younger-instruction slots squashed after a redirect; 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and all state this cycle.
- instr_valid  in  1  br_sel/jmp_sel belong to a real instruction this cycle.
- br_sel  in  3  000 none, 001 EQ, 010 GT(s), 011 NE, 100 LT(s), 101 GE(s), 110 LO(u), 111 always.
- jmp_sel  in  2  00 none, 01 imm target, 10 reg target, 11 halt.
- zero, carry, overflow, negative  in  1 each  ALU flags (carry=1 means no borrow).
- imm_addr, reg_addr, br_addr  in  ADDR_W  jump-immediate, jump-register, branch targets.
- resume  in  1  leave HALT.
- pc  out  ADDR_W  current fetch address.
- next_sel  out  2  00 sequential, 01 jump, 11 branch, 10 hold (halt); combinational.
- redirect  out  1  taken branch/jump accepted this cycle; combinational.
- flush  out  1  squash younger pipeline slot this cycle; registered.
- halted  out  1  state is HALT; registered.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_ADDR, state=RUN, flush=0, halted=0, flush counter=0.
  - Reset mid-flush or mid-halt aborts immediately to these values.
- Conditions:
  - EQ=zero; NE=!zero.
  - GT=!zero&&(negative==overflow); LT=negative!=overflow; GE=negative==overflow.
  - LO=!carry; always=1; none=0.
- Instruction acceptance: an instruction is "accepted" when instr_valid=1, stall=0, state=RUN.
- Priority within an accepted instruction: jmp_sel≠00 wins over br_sel.
  - jmp 11: next_sel=10, pc holds, state→HALT.
  - jmp 01: target=imm_addr, next_sel=01, redirect=1.
  - jmp 10: target=reg_addr, next_sel=01, redirect=1.
  - Else br_sel condition true: target=br_addr, next_sel=11, redirect=1.
  - Else next_sel=00, pc+=INSTR_BYTES.
- Target alignment: low log2(INSTR_BYTES) bits of any target are forced to 0.
- PC arithmetic wraps modulo 2^ADDR_W; no overflow flag.
- States:
  - RUN: normal; when redirect and FLUSH_SLOTS>0, counter←FLUSH_SLOTS and state→FLUSH.
  - FLUSH:
    - flush=1 each non-stalled cycle; counter decrements per non-stalled cycle; at 0, state→RUN.
    - instr_valid ignored (squashed), so no redirect/halt; pc advances sequentially.
    - flush holds its value while stalled.
  - HALT:
    - pc frozen; next_sel=10, redirect=0, flush=0.
    - resume=1 (stall=0) → RUN next cycle, pc=pc+INSTR_BYTES.
- Stall: pc, state and counter hold; redirect=0; next_sel reflects the held decision but is not acted on.
- Latency: pc shows the redirect target the cycle after the accepting edge.
- Stall and resume together: resume ignored until stall=0.

Optional Feature:
- Macro PC_BRANCH_STATS_EN.
- Defined:
  - Adds 32-bit outputs br_taken_cnt and br_total_cnt.
  - br_total_cnt increments on every accepted instruction with br_sel≠000.
  - br_taken_cnt increments when that branch is taken.
  - Both saturate at all-ones and are reset to 0 by rst_n.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset: rst_n=0 mid-FLUSH with RESET_ADDR=0x100 → pc=0x100, flush=0, halted=0 immediately; 3 sequential cycles → pc=0x10C.
- Conditions: pc=0x20, br_sel=010, negative=1, overflow=1, zero=0, br_addr=0x80 → redirect=1, next_sel=11, pc=0x80 next cycle. Same with zero=1 → pc=0x24.
- Flush: FLUSH_SLOTS=2, taken jump to 0x40 with jmp_sel=01 → flush=1 for exactly 2 cycles. A valid EQ-true branch presented during flush is ignored; pc goes 0x40, 0x44, 0x48.
- Priority/alignment: jmp_sel=10, reg_addr=0x1236, br_sel=111 → next_sel=01, pc=0x1234.
- Halt: jmp_sel=11 at pc=0x50 → halted=1, pc stays 0x50 for 5 cycles. resume with stall=1 → no change. resume with stall=0 → halted=0, pc=0x54.
- Wrap: ADDR_W=8, pc=0xFC, sequential → pc=0x00. With PC_BRANCH_STATS_EN, 3 branches with 1 taken → br_total_cnt=3, br_taken_cnt=1.
